pattern_sender: RTL and testbench

- Serial frame transmitter that drives the single-bit line monitored by the team's "1001" sequence checker.
- Each frame is: sync header 1001, then a DATA_W-bit payload sent MSB first with zero-stuffing, then a 3-bit all-zero guard.
- Stuffing and guard together guarantee that the stream contains "1001" only at each frame's header. A downstream overlapping detector therefore fires exactly once per frame.

---
 rtl/pattern_sender.sv | 130 +++++++++++++
 tb/tb_pattern_sender.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sender.sv
// Serial frame transmitter: 1001 header, MSB-first zero-stuffed payload, 3-bit zero guard.
// Latency: first header bit on x the cycle after start is accepted; frame_done on the last guard bit.
// Backpressure: start is accepted only while ready=1; a start seen while busy is dropped, not queued.
module pattern_sender #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              busy,
    output logic              x,
    output logic              frame_done,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DATA  = 3'd2,
        STUFF = 3'd3,
        GUARD = 3'd4
    } state_t;

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            st;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     bits_left;
    logic [2:0]        hdr_sr;
    logic [1:0]        cnt;
    logic [2:0]        hist;

    assign state = st;

    // x, state and hist always describe the same cycle: each branch loads the bit of the state it enters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= IDLE;
            x          <= 1'b0;
            frame_done <= 1'b0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            shreg      <= '0;
            bits_left  <= '0;
            hdr_sr     <= '0;
            cnt        <= '0;
            hist       <= '0;
        end else begin
            frame_done <= 1'b0;
            case (st)
                IDLE: begin
                    x <= 1'b0;
                    if (start) begin
                        st     <= SYNC;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        shreg  <= data;
                        x      <= 1'b1;
                        hist   <= {hist[1:0], 1'b1};
                        hdr_sr <= 3'b001;
                        cnt    <= 2'd3;
                    end
                end
                SYNC: begin
                    if (cnt != 2'd0) begin
                        x      <= hdr_sr[2];
                        hist   <= {hist[1:0], hdr_sr[2]};
                        hdr_sr <= {hdr_sr[1:0], 1'b0};
                        cnt    <= cnt - 2'd1;
                    end else begin
                        st        <= DATA;
                        x         <= shreg[DATA_W-1];
                        hist      <= {hist[1:0], shreg[DATA_W-1]};
                        shreg     <= shreg << 1;
                        bits_left <= CW'(DATA_W - 1);
                    end
                end
                DATA: begin
                    if (hist == 3'b100) begin
                        st   <= STUFF;
                        x    <= 1'b0;
                        hist <= 3'b000;
                    end else if (bits_left != '0) begin
                        x         <= shreg[DATA_W-1];
                        hist      <= {hist[1:0], shreg[DATA_W-1]};
                        shreg     <= shreg << 1;
                        bits_left <= bits_left - 1'b1;
                    end else begin
                        st  <= GUARD;
                        x   <= 1'b0;
                        cnt <= 2'd2;
                    end
                end
                STUFF: begin
                    if (bits_left != '0) begin
                        st        <= DATA;
                        x         <= shreg[DATA_W-1];
                        hist      <= {hist[1:0], shreg[DATA_W-1]};
                        shreg     <= shreg << 1;
                        bits_left <= bits_left - 1'b1;
                    end else begin
                        st  <= GUARD;
                        x   <= 1'b0;
                        cnt <= 2'd2;
                    end
                end
                GUARD: begin
                    x <= 1'b0;
                    if (cnt != 2'd0) begin
                        cnt        <= cnt - 2'd1;
                        frame_done <= (cnt == 2'd1);
                    end else begin
                        st    <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    st    <= IDLE;
                    x     <= 1'b0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_sender.sv
// Bench for pattern_sender: fixed vectors, stuffing corner cases, busy/abort, back-to-back, random frames.
module tb_pattern_sender;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data = '0;
    logic         ready, busy, x, frame_done;
    logic [2:0]   state;

    int errors = 0;
    int checks = 0;
    bit cap[$];
    bit exp_q[$];
    bit all_q[$];

    typedef struct {
        logic [W-1:0] d;
        int           len;
        int           stuff;
        logic [31:0]  bits;
    } vec_t;
    vec_t tbl[5];

    pattern_sender #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data),
        .ready(ready), .busy(busy), .x(x), .frame_done(frame_done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference stream: header, payload with a 0 inserted after every 100 seen on the line, guard.
    function automatic int model(input logic [W-1:0] d);
        int s = 0;
        int n;
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        for (int i = W - 1; i >= 0; i--) begin
            exp_q.push_back(d[i]);
            n = exp_q.size();
            if (exp_q[n-3] && !exp_q[n-2] && !exp_q[n-1]) begin
                exp_q.push_back(1'b0);
                s++;
            end
        end
        repeat (3) exp_q.push_back(1'b0);
        return s;
    endfunction

    function automatic int count_seq(input bit q[$], output int first);
        int n = 0;
        first = -1;
        for (int i = 3; i < q.size(); i++)
            if (q[i-3] && !q[i-2] && !q[i-1] && q[i]) begin
                if (first < 0) first = i;
                n++;
            end
        return n;
    endfunction

    // Receiver: after any 100 on the line inside a payload, the next bit is a stuff bit and is skipped.
    function automatic logic [W-1:0] decode(input bit q[$], input int h);
        logic [W-1:0] d = '0;
        int i = h + 1;
        for (int k = 0; k < W; k++) begin
            d = {d[W-2:0], q[i]};
            i++;
            if (q[i-3] && !q[i-2] && !q[i-1]) i++;
        end
        return d;
    endfunction

    // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
    task automatic run_frame(input logic [W-1:0] d, input int poke, output int len, output int nstuff);
        int fd_cnt = 0;
        int busy_bad = 0;
        cap.delete();
        nstuff = 0;
        len = 0;
        check("ready_before", int'(ready), 1);
        start = 1'b1;
        data = d;
        @(negedge clk);
        start = 1'b0;
        data = W'($urandom);
        for (int c = 1; c <= 40; c++) begin
            cap.push_back(x);
            all_q.push_back(x);
            if (c == 1) check("first_state", int'(state), 1);
            if (state == 3'd3) nstuff++;
            if (busy !== 1'b1 || ready !== 1'b0) busy_bad++;
            if (frame_done) fd_cnt++;
            start = (c == poke);
            if (start) data = ~d;
            len = c;
            if (frame_done) break;
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        all_q.push_back(x);
        check("frame_done_count", fd_cnt, 1);
        check("busy_in_frame", busy_bad, 0);
        check("ready_after", int'(ready), 1);
        check("busy_after", int'(busy), 0);
        check("idle_x", int'(x), 0);
        check("idle_state", int'(state), 0);
    endtask

    task automatic do_frame(input logic [W-1:0] d, input int poke, input string tag,
                            output int len, output int ns);
        int s, bad, first;
        bad = 0;
        run_frame(d, poke, len, ns);
        s = model(d);
        check({tag, "_len"}, len, exp_q.size());
        check({tag, "_stuff"}, ns, s);
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            if (cap[i] != exp_q[i]) bad++;
        check({tag, "_bits"}, bad, 0);
        check({tag, "_hdr_count"}, count_seq(cap, first), 1);
        check({tag, "_hdr_pos"}, first, 3);
    endtask

    initial begin
        int len, ns, bad, first, xbad;
        int hq[$];
        logic [W-1:0] ds[4];

        tbl[0] = '{8'hFF, 15, 0, 32'b100111111111000};
        tbl[1] = '{8'h00, 16, 1, 32'b1001000000000000};
        tbl[2] = '{8'h90, 17, 2, 32'b10011000100000000};
        tbl[3] = '{8'h24, 18, 3, 32'b100100010001000000};
        tbl[4] = '{8'hAA, 15, 0, 32'b100110101010000};

        // Reset state
        #2 reset = 1'b0;
        data = 8'hFF;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_x", int'(x), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(state), 0);
        check("rst_done", int'(frame_done), 0);
        start = 1'b0;
        reset = 1'b1;
        xbad = 0;
        repeat (5) begin
            @(negedge clk);
            if (x !== 1'b0 || ready !== 1'b1 || state !== 3'd0) xbad++;
        end
        check("idle_after_reset", xbad, 0);

        // Fixed vectors
        for (int i = 0; i < 5; i++) begin
            do_frame(tbl[i].d, 0, $sformatf("tbl%0d", i), len, ns);
            check($sformatf("tbl%0d_len_const", i), len, tbl[i].len);
            check($sformatf("tbl%0d_stuff_const", i), ns, tbl[i].stuff);
            bad = 0;
            for (int k = 0; k < tbl[i].len && k < cap.size(); k++)
                if (cap[k] != tbl[i].bits[tbl[i].len-1-k]) bad++;
            check($sformatf("tbl%0d_bits_const", i), bad, 0);
        end

        // start pulsed during DATA is ignored
        do_frame(8'h90, 7, "busy_poke", len, ns);
        check("busy_poke_len", len, 17);
        @(negedge clk);
        check("busy_poke_no_restart", int'(state), 0);

        // Abort in the 6th cycle of a frame
        start = 1'b1;
        data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_abort_x", int'(x), 1);
        reset = 1'b0;
        #1;
        check("abort_x", int'(x), 0);
        check("abort_state", int'(state), 0);
        check("abort_ready", int'(ready), 1);
        check("abort_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_frame(8'h5A, 0, "after_abort", len, ns);

        // Back-to-back at minimum spacing
        all_q.delete();
        for (int f = 0; f < 4; f++) begin
            ds[f] = W'($urandom);
            do_frame(ds[f], 0, $sformatf("b2b%0d", f), len, ns);
        end
        for (int i = 3; i < all_q.size(); i++)
            if (all_q[i-3] && !all_q[i-2] && !all_q[i-1] && all_q[i]) hq.push_back(i);
        check("b2b_z_pulses", hq.size(), 4);
        for (int f = 0; f < 4 && f < hq.size(); f++)
            check($sformatf("b2b%0d_decode", f), int'(decode(all_q, hq[f])), int'(ds[f]));

        // Random frames against the model, including stuff-bound check
        for (int r = 0; r < 30; r++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            if (r % 4 == 0) d = d & W'($urandom);
            do_frame(d, (r % 3 == 0) ? int'($urandom_range(2, 12)) : 0, $sformatf("rnd%0d", r), len, ns);
            check($sformatf("rnd%0d_stuff_bound", r), int'(ns <= (W + 2) / 3), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
